branch_predictor: RTL and testbench

- Parametrised two-level branch direction predictor; successor to the single-port local BHT/PHT predictor.
- Serves N_PRED fetch-side lookups per cycle from registered tables.
- Accepts N_UPD retire-side training updates per cycle, applied in port order.
- MODE selects local history (per-PC BHT) or gshare (global history XOR PC). Counters saturate instead of wrapping.

---
 rtl/branch_predictor_pkg.sv | 25 ++
 rtl/branch_predictor_if.sv | 14 +
 rtl/sat_counter_next.sv | 10 +
 rtl/branch_predictor.sv | 82 ++++++++
 tb/tb_branch_predictor.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared sizing defaults, counter reset value and debug snapshot type
`ifndef BP_BHT_IDX_BITS
`define BP_BHT_IDX_BITS 4
`endif
`ifndef BP_HISTORY_BITS
`define BP_HISTORY_BITS 4
`endif
`ifndef BP_CTR_SZ
`define BP_CTR_SZ 2
`endif
`ifndef BP_MODE
`define BP_MODE 0
`endif
package branch_predictor_pkg;
  localparam int BP_BHT_IDX_BITS_D = `BP_BHT_IDX_BITS;
  localparam int BP_HISTORY_BITS_D = `BP_HISTORY_BITS;
  localparam int BP_CTR_SZ_D = `BP_CTR_SZ;
  localparam int BP_MODE_D = `BP_MODE;
  localparam logic [BP_CTR_SZ_D-1:0] BP_CTR_RESET = BP_CTR_SZ_D'((1 << (BP_CTR_SZ_D - 1)) - 1);
  typedef struct packed {
    logic [(1 << BP_BHT_IDX_BITS_D)-1:0][BP_HISTORY_BITS_D-1:0] bht;
    logic [(1 << BP_HISTORY_BITS_D)-1:0][BP_CTR_SZ_D-1:0] pht;
    logic [BP_HISTORY_BITS_D-1:0] ghr;
  } bp_debug_t;
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side lookup and retire-side update bundle
interface branch_predictor_if #(
  parameter int N_PRED = 2,
  parameter int N_UPD = 2
);
  logic [N_PRED-1:0] pred_valid;
  logic [N_PRED-1:0][31:0] pred_pc;
  logic [N_PRED-1:0] pred_taken;
  logic [N_UPD-1:0] upd_valid;
  logic [N_UPD-1:0][31:0] upd_pc;
  logic [N_UPD-1:0] upd_taken;
  modport master (output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, input pred_taken);
  modport slave (input pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, output pred_taken);
endinterface

// File: rtl/sat_counter_next.sv
// sat_counter_next: saturating increment/decrement of a CTR_SZ-bit counter
module sat_counter_next #(
  parameter int CTR_SZ = 2
) (
  input  logic [CTR_SZ-1:0] ctr,
  input  logic              up,
  output logic [CTR_SZ-1:0] nxt
);
  assign nxt = up ? ((&ctr) ? ctr : ctr + 1'b1) : ((|ctr) ? ctr - 1'b1 : ctr);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: multi-port two-level direction predictor, local history or gshare
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int N_PRED = 2,
  parameter int N_UPD = 2,
  parameter int BHT_IDX_BITS = BP_BHT_IDX_BITS_D,
  parameter int HISTORY_BITS = BP_HISTORY_BITS_D,
  parameter int CTR_SZ = BP_CTR_SZ_D,
  parameter int MODE = BP_MODE_D
) (
  input logic clock,
  input logic reset,
  branch_predictor_if.slave bus
`ifdef DEBUG
  , output bp_debug_t bp_debug
`endif
);
  localparam int BHT_N = 1 << BHT_IDX_BITS;
  localparam int PHT_N = 1 << HISTORY_BITS;
  localparam logic [CTR_SZ-1:0] CTR_RST = CTR_SZ'((1 << (CTR_SZ - 1)) - 1);
  logic [BHT_N-1:0][HISTORY_BITS-1:0] bht_q, bht_d;
  logic [PHT_N-1:0][CTR_SZ-1:0] pht_q, pht_d;
  logic [HISTORY_BITS-1:0] ghr_q, ghr_d;
  function automatic logic [HISTORY_BITS-1:0] pht_idx(
    input logic [BHT_N-1:0][HISTORY_BITS-1:0] bht,
    input logic [HISTORY_BITS-1:0] ghr,
    input logic [31:0] pc
  );
    return (MODE != 0) ? ghr ^ pc[HISTORY_BITS+1:2] : bht[pc[BHT_IDX_BITS+1:2]];
  endfunction
  // lookups read registered tables only, so same-cycle updates are not visible
  always_comb begin
    bus.pred_taken = '0;
    for (int i = 0; i < N_PRED; i++)
      bus.pred_taken[i] = bus.pred_valid[i] & pht_q[pht_idx(bht_q, ghr_q, bus.pred_pc[i])][CTR_SZ-1];
  end
  genvar j;
  for (j = 0; j < N_UPD; j++) begin : s
    logic [BHT_N-1:0][HISTORY_BITS-1:0] bht_i, bht_o;
    logic [PHT_N-1:0][CTR_SZ-1:0] pht_i, pht_o;
    logic [HISTORY_BITS-1:0] ghr_i, ghr_o, idx, hist;
    logic [BHT_IDX_BITS-1:0] pci;
    logic [CTR_SZ-1:0] ctr_n;
    if (j == 0) begin : c
      assign {bht_i, pht_i, ghr_i} = {bht_q, pht_q, ghr_q};
    end else begin : c
      assign {bht_i, pht_i, ghr_i} = {s[j-1].bht_o, s[j-1].pht_o, s[j-1].ghr_o};
    end
    assign pci = bus.upd_pc[j][BHT_IDX_BITS+1:2];
    assign idx = pht_idx(bht_i, ghr_i, bus.upd_pc[j]);
    assign hist = (MODE != 0) ? ghr_i : bht_i[pci];
    sat_counter_next #(.CTR_SZ(CTR_SZ)) u_ctr (.ctr(pht_i[idx]), .up(bus.upd_taken[j]), .nxt(ctr_n));
    // layer this port's training on top of the state left by lower-numbered ports
    always_comb begin
      bht_o = bht_i;
      pht_o = pht_i;
      ghr_o = ghr_i;
      if (bus.upd_valid[j]) begin
        pht_o[idx] = ctr_n;
        if (MODE != 0) ghr_o = {hist[HISTORY_BITS-2:0], bus.upd_taken[j]};
        else bht_o[pci] = {hist[HISTORY_BITS-2:0], bus.upd_taken[j]};
      end
    end
  end
  assign {bht_d, pht_d, ghr_d} = {s[N_UPD-1].bht_o, s[N_UPD-1].pht_o, s[N_UPD-1].ghr_o};
  // table registers; reset leaves every counter weakly not-taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bht_q <= '0;
      pht_q <= {PHT_N{CTR_RST}};
      ghr_q <= '0;
    end else begin
      bht_q <= bht_d;
      pht_q <= pht_d;
      ghr_q <= ghr_d;
    end
  end
`ifdef DEBUG
  assign bp_debug = {bht_q, pht_q, ghr_q};
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of local and gshare predictor instances
module tb_branch_predictor;
  import branch_predictor_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  branch_predictor_if #(.N_PRED(2), .N_UPD(2)) bus0 ();
  branch_predictor_if #(.N_PRED(2), .N_UPD(2)) bus1 ();
`ifdef DEBUG
  bp_debug_t dbg0, dbg1;
`endif
  branch_predictor #(.MODE(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
`ifdef DEBUG
    , .bp_debug(dbg0)
`endif
  );
  branch_predictor #(.MODE(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
`ifdef DEBUG
    , .bp_debug(dbg1)
`endif
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    bus0.upd_valid = '0;
    bus1.upd_valid = '0;
  endtask
  task automatic upd0(input int p, input logic [31:0] pc, input logic t);
    bus0.upd_valid[p] = 1'b1;
    bus0.upd_pc[p] = pc;
    bus0.upd_taken[p] = t;
  endtask
  task automatic upd1(input int p, input logic [31:0] pc, input logic t);
    bus1.upd_valid[p] = 1'b1;
    bus1.upd_pc[p] = pc;
    bus1.upd_taken[p] = t;
  endtask
  task automatic look0(input int p, input logic [31:0] pc);
    bus0.pred_valid[p] = 1'b1;
    bus0.pred_pc[p] = pc;
  endtask
  task automatic look1(input int p, input logic [31:0] pc);
    bus1.pred_valid[p] = 1'b1;
    bus1.pred_pc[p] = pc;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    {bus0.pred_valid, bus0.pred_pc, bus0.upd_valid, bus0.upd_pc, bus0.upd_taken} = '0;
    {bus1.pred_valid, bus1.pred_pc, bus1.upd_valid, bus1.upd_pc, bus1.upd_taken} = '0;
    repeat (2) @(posedge clock);
    #1;
    look0(0, 32'h100);
    look0(1, 32'hFFC);
    #1;
    chk("rst_pred", bus0.pred_taken, 2'b00);
    chk("rst_pht", dut0.pht_q, 32'h5555_5555);
    chk("rst_bht", dut0.bht_q, 64'h0);
    reset = 1'b0;
    repeat (4) begin
      upd0(0, 32'h100, 1'b1);
      tick();
    end
    chk("train_bht0", dut0.bht_q[0], 4'hF);
    chk("train_pht_0137", {dut0.pht_q[0], dut0.pht_q[1], dut0.pht_q[3], dut0.pht_q[7]}, 8'b10_10_10_10);
    chk("train_pht15_pre", dut0.pht_q[15], 2'd1);
    upd0(0, 32'h100, 1'b1);
    #1;
    chk("hazard_same_cycle", bus0.pred_taken[0], 1'b1 ^ 1'b1);
    tick();
    chk("hazard_next_cycle", bus0.pred_taken[0], 1'b1);
    chk("train_pht15", dut0.pht_q[15], 2'd2);
    look0(1, 32'h100);
    bus0.pred_valid[1] = 1'b0;
    #1;
    chk("pred_valid_low", bus0.pred_taken[1], 1'b0);
    repeat (3) begin
      upd0(0, 32'h100, 1'b1);
      tick();
    end
    chk("sat_high", dut0.pht_q[15], 2'd3);
    upd0(0, 32'h100, 1'b0);
    tick();
    chk("sat_dec_pht15", dut0.pht_q[15], 2'd2);
    chk("sat_dec_bht0", dut0.bht_q[0], 4'hE);
    chk("pred_new_hist", bus0.pred_taken[0], 1'b0);
    bus0.upd_pc[0] = 32'h100;
    bus0.upd_taken[0] = 1'b1;
    @(posedge clock);
    #1;
    chk("upd_valid_low_pht14", dut0.pht_q[14], 2'd1);
    chk("upd_valid_low_bht0", dut0.bht_q[0], 4'hE);
    look0(1, 32'h104);
    #1;
    chk("alias_pre_reset", bus0.pred_taken[1], 1'b1);
    upd0(0, 32'h104, 1'b1);
    upd0(1, 32'h100, 1'b1);
    reset = 1'b1;
    #1;
    chk("midreset_pred", bus0.pred_taken, 2'b00);
    tick();
    reset = 1'b0;
    look0(0, 32'h0);
    look0(1, 32'hFFC);
    #1;
    chk("midreset_pht", dut0.pht_q, 32'h5555_5555);
    chk("midreset_bht", dut0.bht_q, 64'h0);
    chk("post_reset_pred", bus0.pred_taken, 2'b00);
    repeat (2) begin
      upd0(0, 32'h100, 1'b0);
      tick();
    end
    chk("sat_low", dut0.pht_q[0], 2'd0);
    pulse_reset();
    upd0(0, 32'h0, 1'b1);
    upd0(1, 32'h4, 1'b1);
    tick();
    chk("accum_pht0", dut0.pht_q[0], 2'd3);
    chk("accum_bht01", {dut0.bht_q[1], dut0.bht_q[0]}, 8'h11);
    pulse_reset();
    upd0(0, 32'h140, 1'b1);
    upd0(1, 32'h140, 1'b1);
    tick();
    chk("dual_pht01", {dut0.pht_q[1], dut0.pht_q[0]}, 4'b10_10);
    chk("dual_bht0", dut0.bht_q[0], 4'b0011);
    look0(0, 32'h100);
    look0(1, 32'h104);
    #1;
    chk("dual_pred", bus0.pred_taken, 2'b10);
    upd1(0, 32'h4, 1'b1);
    tick();
    upd1(0, 32'h8, 1'b1);
    tick();
    chk("gs_ghr", dut1.ghr_q, 4'b0011);
    chk("gs_pht13", {dut1.pht_q[3], dut1.pht_q[1]}, 4'b10_10);
    chk("gs_bht_unused", dut1.bht_q, 64'h0);
    look1(0, 32'hC);
    look1(1, 32'h8);
    #1;
    chk("gs_pred", bus1.pred_taken, 2'b10);
    upd1(0, 32'h0, 1'b1);
    upd1(1, 32'h0, 1'b1);
    tick();
    chk("gs_dual_ghr", dut1.ghr_q, 4'hF);
    chk("gs_dual_pht37", {dut1.pht_q[7], dut1.pht_q[3]}, 4'b10_11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
